// File: rtl/axi_burst_mem_slave_if.sv
// AXI4 bus bundle for axi_burst_mem_slave: AW/W/B/AR/R channels.
// The slave modport is used by the memory responder and the master modport by a driver.
interface axi_burst_mem_slave_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   AWID;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [ID_WIDTH-1:0]   BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    logic [ID_WIDTH-1:0]   ARID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [ID_WIDTH-1:0]   RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory responder with independent write/read engines (INCR/FIXED/WRAP).
// Optional macro AXI_SLV_RD_LATENCY_EN adds RD_LATENCY cycles before the first read beat.
module axi_burst_mem_slave #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
`ifdef AXI_SLV_RD_LATENCY_EN
    ,
    parameter int RD_LATENCY = 4
`endif
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    axi_burst_mem_slave_if.slave  s_axi
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFFSET     = $clog2(STRB_WIDTH);
    localparam int MEM_AW     = $clog2(MEM_DEPTH);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_DATA = 2'd1;
`ifdef AXI_SLV_RD_LATENCY_EN
    localparam logic [1:0] R_WAIT = 2'd2;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic [ADDR_WIDTH-1:0] toIdx(input logic [ADDR_WIDTH-1:0] addr);
        return addr >> OFFSET;
    endfunction

    function automatic logic outOfRange(input logic [ADDR_WIDTH-1:0] idx);
        return idx >= ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    // WRAP keeps the upper index bits and lets the low len bits roll over.
    function automatic logic [ADDR_WIDTH-1:0] nextIdx(input logic [ADDR_WIDTH-1:0] idx,
                                                      input logic [1:0]            burst,
                                                      input logic [7:0]            len);
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] result;
        mask = ADDR_WIDTH'(len);
        case (burst)
            2'b00:   result = idx;
            2'b10:   result = (idx & ~mask) | ((idx + ADDR_WIDTH'(1)) & mask);
            default: result = idx + ADDR_WIDTH'(1);
        endcase
        return result;
    endfunction

    function automatic logic burstErr(input logic [2:0] size,
                                      input logic [1:0] burst,
                                      input logic [7:0] len);
        logic wrapOk;
        wrapOk = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != 3'(OFFSET)) || (burst == 2'b11) || ((burst == 2'b10) && !wrapOk);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] readWord(input logic [ADDR_WIDTH-1:0] idx);
        logic [DATA_WIDTH-1:0] word;
        word = '0;
        if (!outOfRange(idx)) word = mem[idx[MEM_AW-1:0]];
        return word;
    endfunction

    logic [1:0]            wState_q, wState_d;
    logic [ID_WIDTH-1:0]   wId_q,    wId_d;
    logic [ADDR_WIDTH-1:0] wIdx_q,   wIdx_d;
    logic [7:0]            wLen_q,   wLen_d;
    logic [1:0]            wBurst_q, wBurst_d;
    logic [7:0]            wCnt_q,   wCnt_d;
    logic                  wErr_q,   wErr_d;
    logic                  wBeat;
    logic                  wLastBeat;

    assign wBeat     = (wState_q == W_DATA) && s_axi.WVALID;
    assign wLastBeat = (wCnt_q == wLen_q);

    // Burst ends on the beat count; WLAST only feeds the error flag.
    always_comb begin
        wState_d = wState_q;
        wId_d    = wId_q;
        wIdx_d   = wIdx_q;
        wLen_d   = wLen_q;
        wBurst_d = wBurst_q;
        wCnt_d   = wCnt_q;
        wErr_d   = wErr_q;
        case (wState_q)
            W_IDLE: begin
                if (s_axi.AWVALID) begin
                    wId_d    = s_axi.AWID;
                    wIdx_d   = toIdx(s_axi.AWADDR);
                    wLen_d   = s_axi.AWLEN;
                    wBurst_d = s_axi.AWBURST;
                    wCnt_d   = '0;
                    wErr_d   = burstErr(s_axi.AWSIZE, s_axi.AWBURST, s_axi.AWLEN);
                    wState_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi.WVALID) begin
                    wIdx_d = nextIdx(wIdx_q, wBurst_q, wLen_q);
                    wCnt_d = wCnt_q + 8'd1;
                    if (outOfRange(wIdx_q) || (s_axi.WLAST != wLastBeat)) wErr_d = 1'b1;
                    if (wLastBeat) wState_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi.BREADY) wState_d = W_IDLE;
            end
            default: wState_d = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wState_q <= W_IDLE;
            wId_q    <= '0;
            wIdx_q   <= '0;
            wLen_q   <= '0;
            wBurst_q <= '0;
            wCnt_q   <= '0;
            wErr_q   <= 1'b0;
        end else begin
            wState_q <= wState_d;
            wId_q    <= wId_d;
            wIdx_q   <= wIdx_d;
            wLen_q   <= wLen_d;
            wBurst_q <= wBurst_d;
            wCnt_q   <= wCnt_d;
            wErr_q   <= wErr_d;
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge S_AXI_ACLK) begin
        if (wBeat && !outOfRange(wIdx_q)) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi.WSTRB[b]) mem[wIdx_q[MEM_AW-1:0]][8*b +: 8] <= s_axi.WDATA[8*b +: 8];
            end
        end
    end

    assign s_axi.AWREADY = (wState_q == W_IDLE);
    assign s_axi.WREADY  = (wState_q == W_DATA);
    assign s_axi.BVALID  = (wState_q == W_RESP);
    assign s_axi.BID     = wId_q;
    assign s_axi.BRESP   = ((wState_q == W_RESP) && wErr_q) ? RESP_SLVERR : RESP_OKAY;

    logic [1:0]            rState_q, rState_d;
    logic [ID_WIDTH-1:0]   rId_q,    rId_d;
    logic [ADDR_WIDTH-1:0] rIdx_q,   rIdx_d;
    logic [7:0]            rLen_q,   rLen_d;
    logic [1:0]            rBurst_q, rBurst_d;
    logic [7:0]            rCnt_q,   rCnt_d;
    logic                  rErr_q,   rErr_d;
    logic [DATA_WIDTH-1:0] rData_q,  rData_d;
    logic [1:0]            rResp_q,  rResp_d;
    logic                  doLoad;
    logic [ADDR_WIDTH-1:0] loadIdx;
    logic                  loadErr;
`ifdef AXI_SLV_RD_LATENCY_EN
    logic [7:0]            rLat_q,   rLat_d;
`endif

    // Each beat's data is captured into rData_q so later writes cannot disturb a stalled beat.
    always_comb begin
        rState_d = rState_q;
        rId_d    = rId_q;
        rIdx_d   = rIdx_q;
        rLen_d   = rLen_q;
        rBurst_d = rBurst_q;
        rCnt_d   = rCnt_q;
        rErr_d   = rErr_q;
        rData_d  = rData_q;
        rResp_d  = rResp_q;
        doLoad   = 1'b0;
        loadIdx  = rIdx_q;
        loadErr  = rErr_q;
`ifdef AXI_SLV_RD_LATENCY_EN
        rLat_d   = rLat_q;
`endif
        case (rState_q)
            R_IDLE: begin
                if (s_axi.ARVALID) begin
                    rId_d    = s_axi.ARID;
                    rIdx_d   = toIdx(s_axi.ARADDR);
                    rLen_d   = s_axi.ARLEN;
                    rBurst_d = s_axi.ARBURST;
                    rCnt_d   = '0;
                    rErr_d   = burstErr(s_axi.ARSIZE, s_axi.ARBURST, s_axi.ARLEN);
                    loadIdx  = rIdx_d;
                    loadErr  = rErr_d;
`ifdef AXI_SLV_RD_LATENCY_EN
                    if (RD_LATENCY > 1) begin
                        rLat_d   = 8'(RD_LATENCY - 1);
                        rState_d = R_WAIT;
                    end else begin
                        doLoad   = 1'b1;
                        rState_d = R_DATA;
                    end
`else
                    doLoad   = 1'b1;
                    rState_d = R_DATA;
`endif
                end
            end
`ifdef AXI_SLV_RD_LATENCY_EN
            R_WAIT: begin
                rLat_d = rLat_q - 8'd1;
                if (rLat_q == 8'd1) begin
                    doLoad   = 1'b1;
                    rState_d = R_DATA;
                end
            end
`endif
            R_DATA: begin
                if (s_axi.RREADY) begin
                    if (rCnt_q == rLen_q) begin
                        rState_d = R_IDLE;
                    end else begin
                        loadIdx = nextIdx(rIdx_q, rBurst_q, rLen_q);
                        rIdx_d  = loadIdx;
                        rCnt_d  = rCnt_q + 8'd1;
                        doLoad  = 1'b1;
                    end
                end
            end
            default: rState_d = R_IDLE;
        endcase
        if (doLoad) begin
            rData_d = readWord(loadIdx);
            rResp_d = (loadErr || outOfRange(loadIdx)) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rState_q <= R_IDLE;
            rId_q    <= '0;
            rIdx_q   <= '0;
            rLen_q   <= '0;
            rBurst_q <= '0;
            rCnt_q   <= '0;
            rErr_q   <= 1'b0;
            rData_q  <= '0;
            rResp_q  <= RESP_OKAY;
`ifdef AXI_SLV_RD_LATENCY_EN
            rLat_q   <= '0;
`endif
        end else begin
            rState_q <= rState_d;
            rId_q    <= rId_d;
            rIdx_q   <= rIdx_d;
            rLen_q   <= rLen_d;
            rBurst_q <= rBurst_d;
            rCnt_q   <= rCnt_d;
            rErr_q   <= rErr_d;
            rData_q  <= rData_d;
            rResp_q  <= rResp_d;
`ifdef AXI_SLV_RD_LATENCY_EN
            rLat_q   <= rLat_d;
`endif
        end
    end

    assign s_axi.ARREADY = (rState_q == R_IDLE);
    assign s_axi.RVALID  = (rState_q == R_DATA);
    assign s_axi.RLAST   = (rState_q == R_DATA) && (rCnt_q == rLen_q);
    assign s_axi.RID     = rId_q;
    assign s_axi.RDATA   = rData_q;
    assign s_axi.RRESP   = rResp_q;
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboard bench for axi_burst_mem_slave: drivers push expected B/R responses,
// a negedge monitor pops and compares them whenever the DUT presents a response.
module tb_axi_burst_mem_slave;
    localparam int DW    = 64;
    localparam int AW    = 32;
    localparam int IW    = 4;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } bExp_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } rExp_t;

    logic clk = 1'b0;
    logic rst_n;

    bExp_t expB[$];
    rExp_t expR[$];
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] wData [16];
    logic [DW-1:0] rData [16];
    logic [0:3]    rReadyPat;

    always #5 clk = ~clk;

    axi_burst_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    axi_burst_mem_slave #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ID_WIDTH  (IW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .s_axi        (bus)
    );

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timeout waiting for handshake", name);
    endtask

    // Monitor: compare every presented response against the queue head, pop on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.BVALID) begin
                if (expB.size() == 0) begin
                    checkOutput("B_unexpected", 64'(bus.BVALID), 64'd0);
                end else begin
                    checkOutput("BID", 64'(bus.BID), 64'(expB[0].id));
                    checkOutput("BRESP", 64'(bus.BRESP), 64'(expB[0].resp));
                    if (bus.BREADY) void'(expB.pop_front());
                end
            end
            if (bus.RVALID) begin
                if (expR.size() == 0) begin
                    checkOutput("R_unexpected", 64'(bus.RVALID), 64'd0);
                end else begin
                    checkOutput("RID", 64'(bus.RID), 64'(expR[0].id));
                    checkOutput("RDATA", bus.RDATA, expR[0].data);
                    checkOutput("RRESP", 64'(bus.RRESP), 64'(expR[0].resp));
                    checkOutput("RLAST", 64'(bus.RLAST), 64'(expR[0].last));
                    if (bus.RREADY) void'(expR.pop_front());
                end
            end
        end
    end

    task automatic doWrite(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [7:0] strb, input int lastBeat,
                           input int bDelay, input logic [1:0] expResp, input int abortAfter);
        bit ok;
        if (abortAfter < 0) expB.push_back('{id: id, resp: expResp});
        bus.AWID    = id;
        bus.AWADDR  = addr;
        bus.AWLEN   = len;
        bus.AWSIZE  = 3'd3;
        bus.AWBURST = burst;
        bus.AWVALID = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = bus.AWREADY;
            @(posedge clk); #1;
        end
        bus.AWVALID = 1'b0;
        if (!ok) timeout("AW");
        for (int i = 0; i <= int'(len) && i != abortAfter; i++) begin
            bus.WDATA  = wData[i];
            bus.WSTRB  = strb;
            bus.WLAST  = (i == lastBeat);
            bus.WVALID = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(negedge clk);
                ok = bus.WREADY;
                @(posedge clk); #1;
            end
            if (!ok) timeout("W");
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        if (abortAfter < 0) begin
            ok = 1'b0;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(negedge clk);
                ok = bus.BVALID;
            end
            if (!ok) timeout("B");
            @(posedge clk); #1;
            repeat (bDelay) begin
                @(posedge clk); #1;
            end
            bus.BREADY = 1'b1;
            @(posedge clk); #1;
            bus.BREADY = 1'b0;
        end
    endtask

    task automatic doRead(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [1:0] expResp);
        bit ok;
        int seen;
        for (int i = 0; i <= int'(len); i++)
            expR.push_back('{id: id, data: rData[i], resp: expResp, last: (i == int'(len))});
        bus.ARID    = id;
        bus.ARADDR  = addr;
        bus.ARLEN   = len;
        bus.ARSIZE  = size;
        bus.ARBURST = burst;
        bus.ARVALID = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = bus.ARREADY;
            @(posedge clk); #1;
        end
        bus.ARVALID = 1'b0;
        if (!ok) timeout("AR");
        seen = 0;
        for (int c = 0; c < 300 && seen <= int'(len); c++) begin
            bus.RREADY = rReadyPat[c % 4];
            @(negedge clk);
            if (bus.RVALID && bus.RREADY) seen++;
            @(posedge clk); #1;
        end
        bus.RREADY = 1'b0;
        if (seen <= int'(len)) timeout("R");
    endtask

    task automatic checkIdleOutputs(input string tag);
        @(negedge clk);
        checkOutput({tag, "_AWREADY"}, 64'(bus.AWREADY), 64'd1);
        checkOutput({tag, "_ARREADY"}, 64'(bus.ARREADY), 64'd1);
        checkOutput({tag, "_WREADY"}, 64'(bus.WREADY), 64'd0);
        checkOutput({tag, "_BVALID"}, 64'(bus.BVALID), 64'd0);
        checkOutput({tag, "_RVALID"}, 64'(bus.RVALID), 64'd0);
        checkOutput({tag, "_RLAST"}, 64'(bus.RLAST), 64'd0);
        checkOutput({tag, "_BID"}, 64'(bus.BID), 64'd0);
        checkOutput({tag, "_RID"}, 64'(bus.RID), 64'd0);
        checkOutput({tag, "_BRESP"}, 64'(bus.BRESP), 64'd0);
        checkOutput({tag, "_RRESP"}, 64'(bus.RRESP), 64'd0);
        checkOutput({tag, "_RDATA"}, bus.RDATA, 64'd0);
    endtask

    task automatic applyStimulus();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        bus.BREADY  = 1'b0; bus.RREADY = 1'b0; bus.WLAST  = 1'b0;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
        bus.WDATA = '0; bus.WSTRB = '0;
        rReadyPat = 4'b1111;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checkIdleOutputs("reset");
        @(posedge clk); #1;

        $display("[TB] INCR write/read of 8 beats");
        for (int i = 0; i < 8; i++) wData[i] = 64'(i);
        doWrite(4'd0, 32'h0, 8'd7, 2'b01, 8'hFF, 7, 0, 2'b00, -1);
        for (int i = 0; i < 8; i++) rData[i] = 64'(i);
        doRead(4'd0, 32'h0, 8'd7, 2'b01, 3'd3, 2'b00);

        $display("[TB] WRAP bursts");
        wData[0] = 64'hA; wData[1] = 64'hB; wData[2] = 64'hC; wData[3] = 64'hD;
        doWrite(4'd1, 32'h28, 8'd3, 2'b10, 8'hFF, 3, 0, 2'b00, -1);
        rData[0] = 64'hA; rData[1] = 64'hB; rData[2] = 64'hC; rData[3] = 64'hD;
        doRead(4'd2, 32'h28, 8'd3, 2'b10, 3'd3, 2'b00);
        rData[0] = 64'hD; rData[1] = 64'hA; rData[2] = 64'hB; rData[3] = 64'hC;
        doRead(4'd3, 32'h20, 8'd3, 2'b01, 3'd3, 2'b00);
        wData[0] = 64'h1; wData[1] = 64'h2; wData[2] = 64'h3;
        doWrite(4'd3, 32'hA0, 8'd2, 2'b10, 8'hFF, 2, 0, 2'b10, -1);

        $display("[TB] FIXED burst and partial strobes");
        doWrite(4'd4, 32'h1E0, 8'd2, 2'b00, 8'hFF, 2, 0, 2'b00, -1);
        rData[0] = 64'h3; rData[1] = 64'h3;
        doRead(4'd4, 32'h1E0, 8'd1, 2'b00, 3'd3, 2'b00);
        wData[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        doWrite(4'd5, 32'hF0, 8'd0, 2'b01, 8'hFF, 0, 0, 2'b00, -1);
        wData[0] = 64'h0;
        doWrite(4'd5, 32'hF0, 8'd0, 2'b01, 8'h0F, 0, 0, 2'b00, -1);
        rData[0] = 64'hFFFF_FFFF_0000_0000;
        doRead(4'd5, 32'hF0, 8'd0, 2'b01, 3'd3, 2'b00);

        $display("[TB] out-of-range and bad size");
        rData[0] = 64'h0; rData[1] = 64'h0;
        doRead(4'd6, 32'(DEPTH * 8), 8'd1, 2'b01, 3'd3, 2'b10);
        wData[0] = 64'hDEAD; wData[1] = 64'hBEEF;
        doWrite(4'd6, 32'(DEPTH * 8), 8'd1, 2'b01, 8'hFF, 1, 0, 2'b10, -1);
        rData[0] = 64'h0;
        doRead(4'd7, 32'h0, 8'd0, 2'b01, 3'd3, 2'b00);
        doRead(4'd7, 32'h0, 8'd0, 2'b01, 3'd2, 2'b10);

        $display("[TB] backpressure and early WLAST");
        for (int i = 0; i < 8; i++) wData[i] = 64'h100 + 64'(i);
        doWrite(4'd8, 32'h140, 8'd7, 2'b01, 8'hFF, 3, 5, 2'b10, -1);
        rReadyPat = 4'b1001;
        for (int i = 0; i < 8; i++) rData[i] = 64'h100 + 64'(i);
        doRead(4'd9, 32'h140, 8'd7, 2'b01, 3'd3, 2'b00);
        rReadyPat = 4'b1111;

        $display("[TB] reset mid-write");
        for (int i = 0; i < 8; i++) wData[i] = 64'h80 + 64'(i);
        doWrite(4'd10, 32'h40, 8'd7, 2'b01, 8'hFF, 7, 0, 2'b00, 3);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_AWREADY", 64'(bus.AWREADY), 64'd1);
        checkOutput("rst_WREADY", 64'(bus.WREADY), 64'd0);
        checkOutput("rst_BVALID", 64'(bus.BVALID), 64'd0);
        @(posedge clk); #1;
        rData[0] = 64'h80; rData[1] = 64'h81; rData[2] = 64'h82;
        doRead(4'd11, 32'h40, 8'd2, 2'b01, 3'd3, 2'b00);
        wData[0] = 64'h5050; wData[1] = 64'h5151;
        doWrite(4'd12, 32'h190, 8'd1, 2'b01, 8'hFF, 1, 0, 2'b00, -1);
        rData[0] = 64'h5050; rData[1] = 64'h5151;
        doRead(4'd12, 32'h190, 8'd1, 2'b01, 3'd3, 2'b00);

        repeat (3) @(posedge clk);
        checkOutput("leftover_B", 64'(expB.size()), 64'd0);
        checkOutput("leftover_R", 64'(expR.size()), 64'd0);
    endtask

    initial begin
        applyStimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end
endmodule
